// File: rtl/tpg_pkg.sv
// Shared definitions for the test-pattern generator: mode encoding, BGR colour constants
// and the colour-bar lookup.
package tpg_pkg;

    typedef enum logic [2:0] {
        MODE_BORDER  = 3'd0,
        MODE_BARS    = 3'd1,
        MODE_CHECKER = 3'd2,
        MODE_HGRAD   = 3'd3,
        MODE_VGRAD   = 3'd4,
        MODE_FRAME   = 3'd5,
        MODE_RSVD6   = 3'd6,
        MODE_RSVD7   = 3'd7
    } tpg_mode_e;

    // Packing is {B, G, R}
    localparam logic [23:0] BGR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BGR_YELLOW  = 24'h00FFFF;
    localparam logic [23:0] BGR_CYAN    = 24'hFFFF00;
    localparam logic [23:0] BGR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BGR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BGR_RED     = 24'h0000FF;
    localparam logic [23:0] BGR_BLUE    = 24'hFF0000;
    localparam logic [23:0] BGR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BGR_WHITE;
            3'd1:    return BGR_YELLOW;
            3'd2:    return BGR_CYAN;
            3'd3:    return BGR_GREEN;
            3'd4:    return BGR_MAGENTA;
            3'd5:    return BGR_RED;
            3'd6:    return BGR_BLUE;
            default: return BGR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/pattern_generator_if.sv
// Video bundle between timing generator, pattern generator and TMDS encoders.
// master = side driving timing/mode, slave = pattern generator.
interface pattern_generator_if #(
    parameter int COORD_W = 10
);
    logic               i_de;
    logic               i_hs;
    logic               i_vs;
    logic [COORD_W-1:0] i_x;
    logic [COORD_W-1:0] i_y;
    logic [2:0]         i_mode;
    logic               o_de;
    logic               o_hs;
    logic               o_vs;
    logic [23:0]        o_bgr;
    logic [15:0]        o_frame_cnt;

    modport master (
        output i_de, i_hs, i_vs, i_x, i_y, i_mode,
        input  o_de, o_hs, o_vs, o_bgr, o_frame_cnt
    );

    modport slave (
        input  i_de, i_hs, i_vs, i_x, i_y, i_mode,
        output o_de, o_hs, o_vs, o_bgr, o_frame_cnt
    );
endinterface

// File: rtl/tpg_box_mover.sv
// Bouncing-box position state, advanced once per frame edge; used only when
// TPG_MOVING_BOX_EN is defined. A turn-around frame flips direction without moving.
module tpg_box_mover #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COORD_W  = 10,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_frame_edge,
    output logic [COORD_W-1:0] o_bx,
    output logic [COORD_W-1:0] o_by
);
    localparam logic [COORD_W-1:0] STEP = COORD_W'(BOX_STEP);

    logic [COORD_W-1:0] r_bx, r_by;
    logic               r_dx_pos, r_dy_pos;
    logic               w_x_turn, w_y_turn;

    assign w_x_turn = r_dx_pos ? ((int'(r_bx) + BOX_SIZE + BOX_STEP) > H_ACTIVE) : (r_bx < STEP);
    assign w_y_turn = r_dy_pos ? ((int'(r_by) + BOX_SIZE + BOX_STEP) > V_ACTIVE) : (r_by < STEP);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_bx     <= '0;
            r_by     <= '0;
            r_dx_pos <= 1'b1;
            r_dy_pos <= 1'b1;
        end else if (i_frame_edge) begin
            if (w_x_turn) r_dx_pos <= ~r_dx_pos;
            else          r_bx     <= r_dx_pos ? r_bx + STEP : r_bx - STEP;
            if (w_y_turn) r_dy_pos <= ~r_dy_pos;
            else          r_by     <= r_dy_pos ? r_by + STEP : r_by - STEP;
        end
    end

    assign o_bx = r_bx;
    assign o_by = r_by;
endmodule

// File: rtl/pattern_generator.sv
// Multi-mode DVI test-pattern source with a 2-cycle pixel pipeline and frame-synchronous mode switch.
// Optional moving-box overlay enabled by defining TPG_MOVING_BOX_EN.
module pattern_generator
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COORD_W    = 10,
    parameter int CHECK_LOG2 = 5,
    parameter int GRAD_SHIFT = 2
`ifdef TPG_MOVING_BOX_EN
    ,
    parameter int BOX_SIZE   = 32,
    parameter int BOX_STEP   = 2
`endif
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    pattern_generator_if.slave bus
);
    localparam int                 BAR_W  = H_ACTIVE / 8;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    logic        r_de1, r_hs1, r_vs1;
    logic        r_de2, r_hs2, r_vs2;
    logic [23:0] r_bgr1, r_bgr2;
    logic [15:0] r_frame_cnt;
    tpg_mode_e   r_mode;

    logic        w_frame_edge;
    logic [2:0]  w_bar_idx;
    logic [7:0]  w_grad_x, w_grad_y;
    logic [23:0] w_pattern, w_pixel;

    // r_vs1 doubles as the registered vsync for edge detection
    assign w_frame_edge = bus.i_vs & ~r_vs1;
    assign w_grad_x     = 8'(bus.i_x >> GRAD_SHIFT);
    assign w_grad_y     = 8'(bus.i_y >> GRAD_SHIFT);

    // Bar index from a compare chain against constant bar boundaries
    always_comb begin
        w_bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(bus.i_x) >= k * BAR_W) w_bar_idx = 3'(k);
        end
    end

    always_comb begin
        w_pattern = BGR_BLACK;
        case (r_mode)
            MODE_BORDER:  w_pattern = (bus.i_x == '0 || bus.i_x == X_LAST ||
                                       bus.i_y == '0 || bus.i_y == Y_LAST) ? BGR_RED : BGR_WHITE;
            MODE_BARS:    w_pattern = bar_colour(w_bar_idx);
            MODE_CHECKER: w_pattern = (bus.i_x[CHECK_LOG2] ^ bus.i_y[CHECK_LOG2]) ? BGR_WHITE : BGR_BLACK;
            MODE_HGRAD:   w_pattern = {w_grad_x, w_grad_x, w_grad_x};
            MODE_VGRAD:   w_pattern = {w_grad_y, w_grad_y, w_grad_y};
            MODE_FRAME:   w_pattern = {8'h00, r_frame_cnt[7:0], 8'hFF - r_frame_cnt[7:0]};
            default:      w_pattern = BGR_BLACK;
        endcase
    end

`ifdef TPG_MOVING_BOX_EN
    localparam logic [COORD_W:0] BOX_EXT = (COORD_W+1)'(BOX_SIZE);

    logic [COORD_W-1:0] w_bx, w_by;
    logic               w_in_box;

    tpg_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .COORD_W  (COORD_W),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box_mover (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_frame_edge (w_frame_edge),
        .o_bx         (w_bx),
        .o_by         (w_by)
    );

    assign w_in_box = (bus.i_x >= w_bx) && ({1'b0, bus.i_x} < ({1'b0, w_bx} + BOX_EXT)) &&
                      (bus.i_y >= w_by) && ({1'b0, bus.i_y} < ({1'b0, w_by} + BOX_EXT));
    assign w_pixel  = w_in_box ? BGR_GREEN : w_pattern;
`else
    assign w_pixel = w_pattern;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_mode      <= MODE_BORDER;
            r_frame_cnt <= '0;
        end else if (w_frame_edge) begin
            r_mode      <= tpg_mode_e'(bus.i_mode);
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_de1  <= 1'b0;
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_bgr1 <= '0;
            r_de2  <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_bgr2 <= '0;
        end else begin
            r_de1  <= bus.i_de;
            r_hs1  <= bus.i_hs;
            r_vs1  <= bus.i_vs;
            r_bgr1 <= bus.i_de ? w_pixel : BGR_BLACK;
            r_de2  <= r_de1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_bgr2 <= r_de1 ? r_bgr1 : BGR_BLACK;
        end
    end

    assign bus.o_de        = r_de2;
    assign bus.o_hs        = r_hs2;
    assign bus.o_vs        = r_vs2;
    assign bus.o_bgr       = r_bgr2;
    assign bus.o_frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_pattern_generator.sv
// Self-checking bench for pattern_generator: behavioural pixel model plus 2-deep expectation pipe.
// Overlay expectations follow TPG_MOVING_BOX_EN when the bench is built with it.
module tb_pattern_generator;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pattern_generator_if bus();

    pattern_generator dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_mode, m_cnt, m_prev_vs;
    int          m_bx, m_by, m_dx, m_dy;
    logic [26:0] m_pipe;

    function automatic logic [23:0] model_pix(input int mode, input int x, input int y,
                                              input int cnt, input int bx, input int by);
        logic [23:0] r;
        logic [7:0]  g;
        int          idx;
        r = 24'h0;
        case (mode)
            0: r = (x == 0 || x == 639 || y == 0 || y == 479) ? 24'h0000FF : 24'hFFFFFF;
            1: begin
                idx = x / 80;
                if (idx > 7) idx = 7;
                case (idx)
                    0: r = 24'hFFFFFF;
                    1: r = 24'h00FFFF;
                    2: r = 24'hFFFF00;
                    3: r = 24'h00FF00;
                    4: r = 24'hFF00FF;
                    5: r = 24'h0000FF;
                    6: r = 24'hFF0000;
                    default: r = 24'h000000;
                endcase
            end
            2: r = ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            3: begin g = 8'((x / 4) % 256); r = {g, g, g}; end
            4: begin g = 8'((y / 4) % 256); r = {g, g, g}; end
            5: begin g = 8'(cnt % 256); r = {8'h00, g, 8'(255 - (cnt % 256))}; end
            default: r = 24'h000000;
        endcase
`ifdef TPG_MOVING_BOX_EN
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) r = 24'h00FF00;
`else
        if (bx < 0 || by < 0) r = 24'h0;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_prev_vs = 0; m_pipe = '0;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    endtask

    // Drives one cycle; returns the expectation for the outputs now visible (previous step's inputs)
    task automatic step(input logic de, input logic hs, input logic vs, input int x, input int y,
                        input int mode, output logic [26:0] exp_now);
        logic [26:0] cur;
        bus.i_de = de; bus.i_hs = hs; bus.i_vs = vs;
        bus.i_x = x[9:0]; bus.i_y = y[9:0]; bus.i_mode = mode[2:0];
        cur = {de, hs, vs, de ? model_pix(m_mode, x, y, m_cnt, m_bx, m_by) : 24'h0};
        @(posedge clk); #1;
        exp_now = m_pipe;
        m_pipe  = cur;
        if (vs && !m_prev_vs) begin
            m_mode = mode;
            m_cnt  = (m_cnt + 1) % 65536;
            if (m_dx > 0) begin if (m_bx + 34 > 640) m_dx = -1; else m_bx += 2; end
            else          begin if (m_bx < 2) m_dx = 1; else m_bx -= 2; end
            if (m_dy > 0) begin if (m_by + 34 > 480) m_dy = -1; else m_by += 2; end
            else          begin if (m_by < 2) m_dy = 1; else m_by -= 2; end
        end
        m_prev_vs = vs;
    endtask

    task automatic pulse_vs(input int mode);
        logic [26:0] e;
        step(1'b0, 1'b0, 1'b1, 0, 0, mode, e);
        step(1'b0, 1'b0, 1'b0, 0, 0, mode, e);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.i_de = 0; bus.i_hs = 0; bus.i_vs = 0; bus.i_x = '0; bus.i_y = '0; bus.i_mode = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr} !== 27'h0) $display("FAIL reset_outputs got %h want 0", {bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr});
        else n_pass++;
        n_checks++;
        if (bus.o_frame_cnt !== 16'h0) $display("FAIL reset_frame_cnt got %0d want 0", bus.o_frame_cnt);
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
    endtask

    // Each entry: pixel then blank; after the blank cycle the pixel is at the output.
    task automatic run_points(input string name, input int mode, input int xs[$], input int ys[$],
                              input logic [23:0] lits[$]);
        logic [26:0] e;
        for (int i = 0; i < xs.size(); i++) begin
            step(1'b1, 1'b0, 1'b0, xs[i], ys[i], mode, e);
            n_checks++;
            if ({bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr} !== e) $display("FAIL %s model got %h want %h", name, {bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr}, e);
            else n_pass++;
            step(1'b0, 1'b1, 1'b0, xs[i], ys[i], mode, e);
            n_checks++;
            if (bus.o_bgr !== lits[i] || bus.o_de !== 1'b1) $display("FAIL %s (%0d,%0d) got de=%b bgr=%h want bgr=%h", name, xs[i], ys[i], bus.o_de, bus.o_bgr, lits[i]);
            else n_pass++;
        end
        step(1'b0, 1'b0, 1'b0, 0, 0, mode, e);
        n_checks++;
        if ({bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr} !== e || bus.o_bgr !== 24'h0) $display("FAIL %s blanking got %h want %h", name, {bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr}, e);
        else n_pass++;
    endtask

    task automatic test_border();
        run_points("border", 0, '{0, 639, 5, 1, 320}, '{0, 5, 479, 1, 240},
                   '{24'h0000FF, 24'h0000FF, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF});
    endtask

    task automatic test_mode_latch();
        // Mid-frame request must be ignored until the next frame edge
        run_points("latch_midframe", 1, '{80}, '{10}, '{24'hFFFFFF});
        pulse_vs(1);
        run_points("bars", 1, '{79, 80, 160, 639, 600}, '{10, 10, 10, 10, 479},
                   '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h000000, 24'h000000});
    endtask

    task automatic test_checker_grad();
        pulse_vs(2);
        run_points("checker", 2, '{31, 32, 32, 0}, '{0, 0, 32, 32},
                   '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF});
        pulse_vs(3);
        run_points("hgrad", 3, '{100, 1023}, '{7, 7}, '{24'h191919, 24'hFFFFFF});
        pulse_vs(4);
        run_points("vgrad", 4, '{3, 3}, '{100, 0}, '{24'h191919, 24'h000000});
    endtask

    task automatic test_frame_tint();
        int guard = 0;
        while ((m_cnt % 256) != 16 && guard < 300) begin
            pulse_vs(5);
            guard++;
        end
        n_checks++;
        if (bus.o_frame_cnt !== 16'(m_cnt)) $display("FAIL tint_frame_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt);
        else n_pass++;
        run_points("tint", 5, '{12}, '{34}, '{24'h0010EF});
    endtask

    task automatic test_frame_count();
        for (int i = 0; i < 1000; i++) begin
            pulse_vs($urandom_range(0, 7));
            if (i % 100 == 99) begin
                n_checks++;
                if (bus.o_frame_cnt !== 16'(m_cnt)) $display("FAIL frame_cnt got %0d want %0d", bus.o_frame_cnt, m_cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [26:0] e;
        logic        vs = 1'b0;
        int          errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) vs = ~vs;
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), vs,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639),
                 $urandom_range(0, 479), $urandom_range(0, 7), e);
            n_checks++;
            if ({bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr} !== e || bus.o_frame_cnt !== 16'(m_cnt)) begin
                if (errs < 10) $display("FAIL random[%0d] got %h/%0d want %h/%0d", i, {bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr}, bus.o_frame_cnt, e, m_cnt);
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_reset_midline();
        logic [26:0] e;
        pulse_vs(3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 100 + i, 50, 3, e);
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr} !== 27'h0 || bus.o_frame_cnt !== 16'h0) $display("FAIL midline_reset got %h/%0d want 0/0", {bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr}, bus.o_frame_cnt);
        else n_pass++;
        @(negedge clk) rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, i, 7, 3, e);
            n_checks++;
            if ({bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr} !== e) $display("FAIL refill[%0d] got %h want %h", i, {bus.o_de, bus.o_hs, bus.o_vs, bus.o_bgr}, e);
            else n_pass++;
        end
    endtask

    task automatic test_box();
        logic [23:0] lit;
`ifdef TPG_MOVING_BOX_EN
        lit = 24'h00FF00;
`else
        lit = 24'h000000;
`endif
        pulse_vs(6);
        run_points("box_in", 6, '{m_bx, m_bx + 31}, '{m_by, m_by + 31}, '{lit, lit});
        run_points("box_out", 6, '{m_bx + 32, m_bx}, '{m_by, m_by + 32}, '{24'h0, 24'h0});
        for (int i = 0; i < 330; i++) pulse_vs(7);
        run_points("box_bounce", 7, '{m_bx, m_bx + 32}, '{m_by, m_by}, '{lit, 24'h0});
    endtask

    initial begin
        test_reset();
        test_border();
        test_mode_latch();
        test_checker_grad();
        test_frame_tint();
        test_frame_count();
        test_random();
        test_reset_midline();
        test_box();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
